fifo_wr_arbiter: RTL



---
 rtl/fifo_arb_pkg.sv | 20 ++
 rtl/fifo_wr_arbiter_rr_pick.sv | 29 ++
 rtl/fifo_wr_arbiter.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO write-port arbiter.
package fifo_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } arb_state_t;

    localparam int STAT_W = 16;

    function automatic int clog2(input int value);
        int w;
        w = 1;
        while ((1 << w) < value) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational rotate-priority picker: first set request strictly above i_ptr, with wrap.
module rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int N  = 4,
    parameter int PW = clog2(N)
) (
    input  logic [N-1:0]  i_req,
    input  logic [PW-1:0] i_ptr,
    output logic [N-1:0]  o_pick,
    output logic          o_valid
);

    logic [PW-1:0] w_idx;

    always_comb begin
        o_pick  = '0;
        o_valid = 1'b0;
        w_idx   = '0;
        for (int i = 1; i <= N; i++) begin
            w_idx = PW'((int'(i_ptr) + i) % N);
            if (!o_valid && i_req[w_idx]) begin
                o_pick[w_idx] = 1'b1;
                o_valid       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin, burst-locking arbiter for a shared FIFO write port.
// Optional per-requester beat statistics are built when FIFO_ARB_STATS_EN is defined.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int DWIDTH    = 8,
    parameter int MAX_BURST = 16
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic [NUM_REQ-1:0]        i_req,
    input  logic [NUM_REQ*DWIDTH-1:0] i_data,
    input  logic [NUM_REQ-1:0]        i_last,
    output logic [NUM_REQ-1:0]        o_ack,
    input  logic                      i_full,
    output logic                      o_wr,
    output logic [DWIDTH-1:0]         o_wdata,
    output logic [NUM_REQ-1:0]        o_grant,
    output logic                      o_busy,
    input  logic                      i_stat_clr,
    output logic [NUM_REQ*STAT_W-1:0] o_stat_beats
);

    // state | meaning
    // IDLE  | no grant held; picks a winner from pending requests
    // LOCK  | r_grant owns the write port until its last beat or the burst cap

    localparam int PW = clog2(NUM_REQ);
    localparam int CW = clog2(MAX_BURST);

    arb_state_t           r_state;
    arb_state_t           w_state_nxt;
    logic [NUM_REQ-1:0]   r_grant;
    logic [PW-1:0]        r_ptr;
    logic [CW-1:0]        r_cnt;

    logic [NUM_REQ-1:0]   w_pick;
    logic                 w_pick_vld;
    logic [PW-1:0]        w_gidx;
    logic [DWIDTH-1:0]    w_gdata;
    logic                 w_greq;
    logic                 w_glast;
    logic                 w_wr;
    logic                 w_rel;

    rr_pick #(
        .N  (NUM_REQ),
        .PW (PW)
    ) u_rr_pick (
        .i_req   (i_req),
        .i_ptr   (r_ptr),
        .o_pick  (w_pick),
        .o_valid (w_pick_vld)
    );

    // Grant is one-hot, so at most one lane is selected here.
    always_comb begin
        w_gidx  = '0;
        w_gdata = '0;
        w_greq  = 1'b0;
        w_glast = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (r_grant[k]) begin
                w_gidx  = PW'(k);
                w_gdata = i_data[k*DWIDTH +: DWIDTH];
                w_greq  = i_req[k];
                w_glast = i_last[k];
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_wr        = 1'b0;
        w_rel       = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_pick_vld) begin
                    w_state_nxt = LOCK;
                end
            end
            LOCK: begin
                w_wr  = w_greq & ~i_full;
                w_rel = w_wr & (w_glast | (r_cnt == CW'(MAX_BURST - 1)));
                if (w_rel) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Pointer starts at the top requester so requester 0 wins the first arbitration.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_grant <= '0;
            r_ptr   <= PW'(NUM_REQ - 1);
            r_cnt   <= '0;
        end else if (r_state == IDLE) begin
            if (w_pick_vld) begin
                r_grant <= w_pick;
            end
        end else if (w_rel) begin
            r_grant <= '0;
            r_ptr   <= w_gidx;
            r_cnt   <= '0;
        end else if (w_wr) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_wr    = w_wr;
    assign o_ack   = w_wr ? r_grant : '0;
    assign o_wdata = (r_state == LOCK) ? w_gdata : '0;
    assign o_grant = r_grant;
    assign o_busy  = (r_state == LOCK);

`ifdef FIFO_ARB_STATS_EN
    logic [STAT_W-1:0] r_stat [NUM_REQ];

    // Clear has priority over a coincident increment; counters saturate.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                r_stat[k] <= '0;
            end
        end else if (i_stat_clr) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                r_stat[k] <= '0;
            end
        end else begin
            for (int k = 0; k < NUM_REQ; k++) begin
                if (o_ack[k] && (r_stat[k] != '1)) begin
                    r_stat[k] <= r_stat[k] + 1'b1;
                end
            end
        end
    end

    for (genvar k = 0; k < NUM_REQ; k++) begin : g_stat_out
        assign o_stat_beats[k*STAT_W +: STAT_W] = r_stat[k];
    end
`else
    logic w_unused_stat_clr;

    assign w_unused_stat_clr = i_stat_clr;
    assign o_stat_beats      = '0;
`endif

endmodule
